// File: rtl/mux_scan_scheduler_if.sv
// Bus bundle between the analog mux scan scheduler and its surroundings
// (period enable/flag control, switcherMUX stepper, ADC handshake and sample/flag outputs).
//   master : the scheduler side (drives strobe, ADC start, sample and flag outputs)
//   slave  : the environment side (drives enable, flag_clear, cnt_channel, ADC result)
interface mux_scan_scheduler_if #(
  parameter int unsigned Dw = 12
) ();
  logic          enable;
  logic          flag_clear;
  logic [4:0]    cnt_channel;
  logic          switch_signal;
  logic          adc_start;
  logic          adc_done;
  logic [Dw-1:0] adc_data;
  logic          sample_valid;
  logic [Dw-1:0] sample_data;
  logic [4:0]    sample_ch;
  logic          frame_start;
  logic          overrun;
  logic          adc_timeout;
  logic          sync_err;

  modport master (
    input  enable, flag_clear, cnt_channel, adc_done, adc_data,
    output switch_signal, adc_start, sample_valid, sample_data, sample_ch, frame_start,
           overrun, adc_timeout, sync_err
  );

  modport slave (
    output enable, flag_clear, cnt_channel, adc_done, adc_data,
    input  switch_signal, adc_start, sample_valid, sample_data, sample_ch, frame_start,
           overrun, adc_timeout, sync_err
  );
endinterface

// File: rtl/mux_scan_scheduler.sv
// Analog mux scan scheduler. Each period tick strobes switch_signal to the switcherMUX stepper,
// waits for the analog path to settle, runs one ADC conversion and emits the result tagged with
// its channel. The stepper's cnt_channel is cross-checked against the local index; on mismatch
// the stepper wins and the local index is reloaded.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : master side of mux_scan_scheduler_if
//            in  : enable, flag_clear, cnt_channel, adc_done, adc_data
//            out : switch_signal, adc_start, sample_valid, sample_data, sample_ch, frame_start,
//                  overrun, adc_timeout, sync_err (last three sticky)
module mux_scan_scheduler #(
  parameter int unsigned PeriodCyc = 2000,
  parameter int unsigned SwHiCyc   = 4,
  parameter int unsigned SettleCyc = 50,
  parameter int unsigned AdcTo     = 255,
  parameter int unsigned NCh       = 18,
  parameter int unsigned Dw        = 12
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  mux_scan_scheduler_if.master bus
);

  localparam int unsigned PeriodW  = $clog2(PeriodCyc);
  localparam int unsigned TimerMax = (AdcTo > SettleCyc) ?
                                     ((AdcTo > SwHiCyc) ? AdcTo : SwHiCyc) :
                                     ((SettleCyc > SwHiCyc) ? SettleCyc : SwHiCyc);
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(PeriodCyc - 1);
  localparam logic [TimerW-1:0]  SwHiLast   = TimerW'(SwHiCyc - 1);
  localparam logic [TimerW-1:0]  SettleLast = TimerW'(SettleCyc - 1);
  localparam logic [TimerW-1:0]  AdcToLast  = TimerW'(AdcTo - 1);
  localparam logic [4:0]         ChLast     = 5'(NCh - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSwHi,
    StSwLo,
    StSettle,
    StConvert,
    StEmit
  } state_e;

  state_e            state_q, state_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [4:0]        ch_idx_q, ch_idx_d;
  logic [Dw-1:0]     sample_data_q, sample_data_d;
  logic [4:0]        sample_ch_q;
  logic              switch_q, adc_start_q, sample_valid_q, frame_start_q;
  logic              overrun_q, adc_timeout_q, sync_err_q;
  logic              tick;
  logic              overrun_set, timeout_set, sync_set;

  // Period timebase: held at zero while disabled so a re-enable always waits a full period.
  always_comb begin
    tick     = bus.enable && (period_q == PeriodLast);
    period_d = period_q + PeriodW'(1);
    if (!bus.enable || tick) begin
      period_d = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TimerW'(1);
    ch_idx_d      = ch_idx_q;
    sample_data_d = sample_data_q;
    timeout_set   = 1'b0;
    sync_set      = 1'b0;
    // A tick that finds a step still in flight is dropped, not queued.
    overrun_set   = tick && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (tick) begin
          state_d  = StSwHi;
          ch_idx_d = (ch_idx_q == ChLast) ? 5'd0 : ch_idx_q + 5'd1;
        end
      end
      StSwHi: begin
        if (timer_q == SwHiLast) begin
          state_d = StSwLo;
          timer_d = '0;
        end
      end
      StSwLo: begin
        state_d = StSettle;
        timer_d = '0;
      end
      StSettle: begin
        if (timer_q == SettleLast) begin
          state_d = StConvert;
          timer_d = '0;
          // The stepper is the authority on which channel is actually selected.
          if (bus.cnt_channel != ch_idx_q) begin
            sync_set = 1'b1;
            ch_idx_d = bus.cnt_channel;
          end
        end
      end
      StConvert: begin
        if (bus.adc_done) begin
          sample_data_d = bus.adc_data;
          state_d       = StEmit;
        end else if (timer_q == AdcToLast) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end
      end
      StEmit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      period_q       <= '0;
      timer_q        <= '0;
      ch_idx_q       <= '0;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      switch_q       <= 1'b0;
      adc_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      overrun_q      <= 1'b0;
      adc_timeout_q  <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      timer_q        <= timer_d;
      ch_idx_q       <= ch_idx_d;
      sample_data_q  <= sample_data_d;
      // Outputs are registered from the next state so they line up with the state they decode.
      switch_q       <= (state_d == StSwHi);
      adc_start_q    <= (state_d == StConvert) && (state_q != StConvert);
      sample_valid_q <= (state_d == StEmit);
      frame_start_q  <= (state_d == StEmit) && (ch_idx_q == 5'd0);
      if (state_d == StEmit) begin
        sample_ch_q <= ch_idx_q;
      end
      // Set wins over a simultaneous clear.
      overrun_q      <= overrun_set | (overrun_q & ~bus.flag_clear);
      adc_timeout_q  <= timeout_set | (adc_timeout_q & ~bus.flag_clear);
      sync_err_q     <= sync_set | (sync_err_q & ~bus.flag_clear);
    end
  end

  assign bus.switch_signal = switch_q;
  assign bus.adc_start     = adc_start_q;
  assign bus.sample_valid  = sample_valid_q;
  assign bus.sample_data   = sample_data_q;
  assign bus.sample_ch     = sample_ch_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.overrun       = overrun_q;
  assign bus.adc_timeout   = adc_timeout_q;
  assign bus.sync_err      = sync_err_q;

endmodule

// File: tb/tb_mux_scan_scheduler.sv
// Bench for mux_scan_scheduler: a 200-cycle-period instance exercises the normal scan, desync,
// ADC timeout, async reset and enable-drop cases; a 40-cycle-period instance exercises overrun.
// Stepper and ADC are behavioural models; expected channels come from step arithmetic.
module tb_mux_scan_scheduler;
  localparam int unsigned Dw    = 12;
  localparam int unsigned AdcTo = 100;
  localparam int unsigned NCh   = 18;

  typedef struct packed {
    logic [4:0]    ch;
    logic [Dw-1:0] data;
    logic          frame;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_scheduler_if #(.Dw(Dw)) bus ();
  mux_scan_scheduler_if #(.Dw(Dw)) obus ();

  mux_scan_scheduler #(
    .PeriodCyc(200), .SwHiCyc(4), .SettleCyc(50), .AdcTo(AdcTo), .NCh(NCh), .Dw(Dw)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  mux_scan_scheduler #(
    .PeriodCyc(40), .SwHiCyc(4), .SettleCyc(50), .AdcTo(AdcTo), .NCh(NCh), .Dw(Dw)
  ) u_ovr (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (obus)
  );

  // Stepper models: advance once per switch_signal high level; off skews the main one.
  int unsigned step_cnt, ostep_cnt, off;
  logic        sw_prev, osw_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 0; ostep_cnt <= 0; sw_prev <= 1'b0; osw_prev <= 1'b0;
    end else begin
      sw_prev  <= bus.switch_signal;
      osw_prev <= obus.switch_signal;
      if (bus.switch_signal && !sw_prev) step_cnt <= (step_cnt + 1) % NCh;
      if (obus.switch_signal && !osw_prev) ostep_cnt <= (ostep_cnt + 1) % NCh;
    end
  end
  assign bus.cnt_channel  = 5'((step_cnt + off) % NCh);
  assign obus.cnt_channel = 5'(ostep_cnt);

  // ADC models: answer about 20 cycles after adc_start unless muted.
  int unsigned   adc_dly, oadc_dly;
  logic          adc_mute;
  logic [Dw-1:0] adc_word;
  logic [Dw-1:0] exp_data_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_dly <= 0; oadc_dly <= 0; adc_word <= '0;
      bus.adc_done <= 1'b0; bus.adc_data <= '0;
      obus.adc_done <= 1'b0; obus.adc_data <= '0;
    end else begin
      adc_word      <= Dw'($urandom);
      bus.adc_done  <= 1'b0;
      obus.adc_done <= 1'b0;
      if (bus.adc_start && !adc_mute) adc_dly <= 20;
      else if (adc_dly != 0) begin
        adc_dly <= adc_dly - 1;
        if (adc_dly == 1) begin
          bus.adc_done <= 1'b1;
          bus.adc_data <= adc_word;
          exp_data_q.push_back(adc_word);
        end
      end
      if (obus.adc_start) oadc_dly <= 20;
      else if (oadc_dly != 0) begin
        oadc_dly <= oadc_dly - 1;
        if (oadc_dly == 1) begin
          obus.adc_done <= 1'b1;
          obus.adc_data <= adc_word;
        end
      end
    end
  end

  // Monitors sample away from the active edge.
  samp_t       samp_q[$];
  int unsigned osamp_q[$];
  int unsigned sw_w_q[$];
  int unsigned strobes = 0, ostrobes = 0, sw_run = 0;
  logic        msw_prev = 1'b0, mosw_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.sample_valid) samp_q.push_back(samp_t'({bus.sample_ch, bus.sample_data,
                                                   bus.frame_start}));
    if (obus.sample_valid) osamp_q.push_back(int'(obus.sample_ch));
    if (bus.switch_signal) begin
      if (!msw_prev) strobes <= strobes + 1;
      sw_run <= sw_run + 1;
    end else if (msw_prev) begin
      sw_w_q.push_back(sw_run);
      sw_run <= 0;
    end
    msw_prev <= bus.switch_signal;
    if (obus.switch_signal && !mosw_prev) ostrobes <= ostrobes + 1;
    mosw_prev <= obus.switch_signal;
  end

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned rd = 0, n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_next_sample(input int unsigned exp_ch, input string tag);
    int unsigned   i = 0;
    samp_t         s;
    logic [Dw-1:0] ed;
    while (samp_q.size() <= rd && i < 600) begin
      @(negedge clk);
      i++;
    end
    check({tag, " arrived"}, 32'(samp_q.size() > rd), 32'd1);
    if (samp_q.size() <= rd) return;
    s = samp_q[rd];
    rd++;
    check({tag, " ch"}, 32'(s.ch), exp_ch);
    check({tag, " frame"}, 32'(s.frame), 32'(exp_ch == 0));
    ed = 'x;
    if (exp_data_q.size() != 0) ed = exp_data_q.pop_front();
    check({tag, " data"}, 32'(s.data), 32'(ed));
  endtask

  task automatic wait_adc_start(input string tag);
    int unsigned i = 0;
    while (!bus.adc_start && i < 400) begin
      @(negedge clk);
      i++;
    end
    check({tag, " adc_start"}, 32'(bus.adc_start), 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clk) bus.flag_clear = 1'b1;
    @(negedge clk) bus.flag_clear = 1'b0;
  endtask

  function automatic logic [31:0] outs_main();
    return 32'({bus.switch_signal, bus.adc_start, bus.sample_valid, bus.sample_data,
                bus.sample_ch, bus.frame_start, bus.overrun, bus.adc_timeout, bus.sync_err});
  endfunction

  initial begin
    int unsigned base, cnt;
    bit          seen;
    bus.enable = 1'b0; bus.flag_clear = 1'b0;
    obus.enable = 1'b0; obus.flag_clear = 1'b0;
    off = 0; adc_mute = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs", outs_main(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset outs", outs_main(), 32'd0);

    // Normal scan of 20 steps wrapping through channel 0.
    bus.enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n++;
      check_next_sample((n + off) % NCh, "scan");
    end
    bus.enable = 1'b0;
    check("scan strobes", strobes, 32'd20);
    check("scan widths", sw_w_q.size(), 32'd20);
    foreach (sw_w_q[i]) check("sw high width", sw_w_q[i], 32'd4);
    check("scan flags", 32'({bus.overrun, bus.adc_timeout, bus.sync_err}), 32'd0);

    // Stepper skewed by one from the fifth step on.
    bus.enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) off = 1;
      n++;
      check_next_sample((n + off) % NCh, "desync");
      if (k == 3) check("sync_err before skew", 32'(bus.sync_err), 32'd0);
      if (k == 4) check("sync_err after skew", 32'(bus.sync_err), 32'd1);
    end
    bus.enable = 1'b0;
    pulse_clear();
    check("sync_err cleared", 32'(bus.sync_err), 32'd0);

    // ADC never answers.
    adc_mute = 1'b1;
    bus.enable = 1'b1;
    base = samp_q.size();
    wait_adc_start("timeout");
    cnt = 0;
    while (!bus.adc_timeout && cnt < AdcTo + 20) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout latency", cnt, AdcTo);
    check("no sample on timeout", samp_q.size(), base);
    n++;
    pulse_clear();
    check("timeout cleared", 32'(bus.adc_timeout), 32'd0);
    adc_mute = 1'b0;
    n++;
    check_next_sample((n + off) % NCh, "after timeout");
    check("no overrun/sync", 32'({bus.overrun, bus.sync_err}), 32'd0);
    bus.enable = 1'b0;

    // Async reset in the middle of SETTLE.
    bus.enable = 1'b1;
    cnt = 0;
    while (!bus.switch_signal && cnt < 400) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (bus.switch_signal && cnt < 20) begin @(negedge clk); cnt++; end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("outs in reset", outs_main(), 32'd0);
    n = 0; off = 0; rd = 0;
    samp_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n++;
    check_next_sample((n + off) % NCh, "after reset");

    // Enable dropped during CONVERT: the step finishes, then the scan stalls.
    wait_adc_start("enable drop");
    bus.enable = 1'b0;
    n++;
    check_next_sample((n + off) % NCh, "enable drop");
    base = strobes;
    repeat (500) @(negedge clk);
    check("stalled strobes", strobes, base);
    bus.enable = 1'b1;
    n++;
    check_next_sample((n + off) % NCh, "re-enable");
    bus.enable = 1'b0;

    // Period shorter than a step: every other tick is dropped.
    seen = 1'b0;
    @(negedge clk) obus.enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (obus.overrun && !seen) begin
        seen = 1'b1;
        check("overrun on first step", ostrobes, 32'd1);
      end
    end
    obus.enable = 1'b0;
    check("overrun seen", 32'(seen), 32'd1);
    repeat (150) @(negedge clk);
    check("ovr strobes", ostrobes, 32'd5);
    check("ovr samples", osamp_q.size(), 32'd5);
    foreach (osamp_q[i]) check("ovr ch", osamp_q[i], i + 1);
    check("ovr flags", 32'({obus.overrun, obus.adc_timeout, obus.sync_err}), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
